sub_cla_pipe: RTL

Two-stage pipelined carry-lookahead subtractor with valid/ready handshakes on both sides. Computes D = A − B − Bin and a borrow-out. It is the inverse-direction counterpart of the combinational CLA adder in the arithmetic library. It sits between operand producers and result consumers that need one result per cycle at a registered timing boundary.

---
 rtl/sub_cla_pipe.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sub_cla_pipe.sv
// Two-stage pipelined carry-lookahead subtractor (D = A - B - Bin) with valid/ready on both sides.
// Optional signed-overflow output is built when SUB_CLA_OVF_EN is defined; otherwise Ovf_o is 0.
module sub_cla_pipe #(
    parameter int unsigned BW_DATA = 32
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [BW_DATA-1:0] A_i,
    input  logic [BW_DATA-1:0] B_i,
    input  logic               Bin_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [BW_DATA-1:0] D_o,
    output logic               Bout_o,
    output logic               Ovf_o
);

    localparam int unsigned H = BW_DATA / 2;

    // H-bit adder built from 4-bit lookahead groups; group carries chain between groups.
    function automatic logic [H:0] cla_half(input logic [H-1:0] a, input logic [H-1:0] b,
                                            input logic cin);
        logic [H-1:0] g, p, s;
        logic [3:0]   gg, pp;
        logic [4:0]   c;
        logic         grp_g;
        logic         carry;
        g     = a & b;
        p     = a ^ b;
        s     = '0;
        carry = cin;
        for (int k = 0; k < int'(H / 4); k++) begin
            gg    = g[4*k +: 4];
            pp    = p[4*k +: 4];
            c[0]  = carry;
            c[1]  = gg[0] | (pp[0] & c[0]);
            c[2]  = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c[0]);
            c[3]  = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                  | (pp[2] & pp[1] & pp[0] & c[0]);
            grp_g = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                  | (pp[3] & pp[2] & pp[1] & gg[0]);
            c[4]  = grp_g | ((&pp) & c[0]);
            s[4*k +: 4] = pp ^ c[3:0];
            carry = c[4];
        end
        return {carry, s};
    endfunction

    logic               s1_valid_q, s1_valid_d;
    logic               out_valid_q, out_valid_d;
    logic [H-1:0]       s1_lo_q;
    logic               s1_bmid_q;
    logic [H-1:0]       s1_a_hi_q;
    logic [H-1:0]       s1_nb_hi_q;
    logic [BW_DATA-1:0] d_q;
    logic               bout_q;

    logic               out_stall;
    logic               s2_adv;
    logic               in_xfer;
    logic               out_xfer;
    logic [H:0]         lo_sum;
    logic [H:0]         hi_sum;

    always_comb begin
        out_stall  = out_valid_q & ~out_ready_i;
        s2_adv     = s1_valid_q & ~out_stall;
        in_ready_o = ~s1_valid_q | s2_adv;
        in_xfer    = in_valid_i & in_ready_o;
        out_xfer   = out_valid_q & out_ready_i;
    end

    // Subtraction as A + ~B + ~Bin; carry out of each half is the inverse of its borrow.
    always_comb begin
        lo_sum = cla_half(A_i[H-1:0], ~B_i[H-1:0], ~Bin_i);
        hi_sum = cla_half(s1_a_hi_q, s1_nb_hi_q, ~s1_bmid_q);
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (in_xfer) begin
            s1_valid_d = 1'b1;
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end
        out_valid_d = out_valid_q;
        if (s2_adv) begin
            out_valid_d = 1'b1;
        end else if (out_xfer) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_lo_q    <= '0;
            s1_bmid_q  <= 1'b0;
            s1_a_hi_q  <= '0;
            s1_nb_hi_q <= '0;
        end else if (in_xfer) begin
            s1_lo_q    <= lo_sum[H-1:0];
            s1_bmid_q  <= ~lo_sum[H];
            s1_a_hi_q  <= A_i[BW_DATA-1:H];
            s1_nb_hi_q <= ~B_i[BW_DATA-1:H];
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            d_q    <= '0;
            bout_q <= 1'b0;
        end else if (s2_adv) begin
            d_q    <= {hi_sum[H-1:0], s1_lo_q};
            bout_q <= ~hi_sum[H];
        end
    end

`ifdef SUB_CLA_OVF_EN
    logic s1_a_sign_q;
    logic s1_b_sign_q;
    logic ovf_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_a_sign_q <= 1'b0;
            s1_b_sign_q <= 1'b0;
        end else if (in_xfer) begin
            s1_a_sign_q <= A_i[BW_DATA-1];
            s1_b_sign_q <= B_i[BW_DATA-1];
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ovf_q <= 1'b0;
        end else if (s2_adv) begin
            ovf_q <= (s1_a_sign_q ^ s1_b_sign_q) & (hi_sum[H-1] ^ s1_a_sign_q);
        end
    end

    assign Ovf_o = ovf_q;
`else
    assign Ovf_o = 1'b0;
`endif

    assign out_valid_o = out_valid_q;
    assign D_o         = d_q;
    assign Bout_o      = bout_q;

endmodule
